// File: rtl/gvt_tracker_if.sv
// GVT tracker request/result bundle.
// Master issues requests and snapshots; slave is the tracker.
interface gvt_tracker_if #(
  parameter int NUM_CORE = 4,
  parameter int TIME_WID = 16
);
  localparam int SW = $clog2(NUM_CORE + 1);

  logic                         req_valid;
  logic                         req_ready;
  logic [TIME_WID*NUM_CORE-1:0] core_times;
  logic [NUM_CORE-1:0]          core_vld;
  logic [TIME_WID-1:0]          next_event;
  logic                         next_event_vld;
  logic [TIME_WID-1:0]          gvt;
  logic                         done;
  logic [SW-1:0]                min_src;
  logic                         regress;
  logic                         busy;

  modport master (
    output req_valid,
    output core_times,
    output core_vld,
    output next_event,
    output next_event_vld,
    input  req_ready,
    input  gvt,
    input  done,
    input  min_src,
    input  regress,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  core_times,
    input  core_vld,
    input  next_event,
    input  next_event_vld,
    output req_ready,
    output gvt,
    output done,
    output min_src,
    output regress,
    output busy
  );
endinterface

// File: rtl/gvt_tracker.sv
// Pipelined GVT tracker: snapshot, registered min-tree,
// monotonic commit with winner index and regression flag.
module gvt_tracker #(
  parameter int NUM_CORE   = 4,
  parameter int TIME_WID   = 16,
  parameter int PIPE_EVERY = 1
) (
  input logic           clk,
  input logic           rst_n,
  gvt_tracker_if.slave  bus
);

  localparam int L       = $clog2(NUM_CORE + 1);
  localparam int NLEAF   = 1 << L;
  localparam int RED_LAT = (PIPE_EVERY == 0) ? 0 :
                           (L + PIPE_EVERY - 1) / PIPE_EVERY;
  localparam int CW      = $clog2(RED_LAT + 2);
  localparam int PE_SAFE = (PIPE_EVERY > 0) ? PIPE_EVERY : 1;

  typedef struct packed {
    logic                vld;
    logic [L-1:0]        src;
    logic [TIME_WID-1:0] val;
  } node_t;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    COMMIT
  } state_t;

  // Left input always holds the lower source indices.
  function automatic node_t pick(node_t a, node_t b);
    node_t r;
    r = '0;
    if (a.vld && b.vld) begin
      r = (b.val < a.val) ? b : a;
    end else if (a.vld) begin
      r = a;
    end else if (b.vld) begin
      r = b;
    end
    return r;
  endfunction

  state_t state;
  state_t state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  logic req_ready;
  logic accept;
  logic commit;

  logic [TIME_WID*NUM_CORE-1:0] cap_times;
  logic [NUM_CORE-1:0]          cap_vld;
  logic [TIME_WID-1:0]          cap_ne;
  logic                         cap_nev;

  logic [TIME_WID-1:0] gvt_q;
  logic [L-1:0]        src_q;
  logic                done_q;
  logic                regress_q;

  node_t [2*NLEAF-1:1] nd;
  node_t root;

  // Heap layout: leaves at NLEAF.., root at 1.
  for (genvar k = 0; k < NLEAF; k++) begin : g_leaf
    if (k < NUM_CORE) begin : g_core
      assign nd[NLEAF+k] = '{
        vld: cap_vld[k],
        src: L'(k),
        val: cap_times[TIME_WID*k +: TIME_WID]
      };
    end else if (k == NUM_CORE) begin : g_evq
      assign nd[NLEAF+k] = '{
        vld: cap_nev,
        src: L'(k),
        val: cap_ne
      };
    end else begin : g_pad
      assign nd[NLEAF+k] = '{
        vld: 1'b0,
        src: L'(k),
        val: '0
      };
    end
  end

  for (genvar i = 1; i < NLEAF; i++) begin : g_node
    localparam int LVL = L - $clog2(i + 1);
    localparam bit REG = (PIPE_EVERY > 0) &&
                         ((LVL == L - 1) ||
                          (((LVL + 1) % PE_SAFE) == 0));
    node_t cmb;

    assign cmb = pick(nd[2*i], nd[2*i+1]);

    if (REG) begin : g_reg
      node_t q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else begin
          q <= cmb;
        end
      end

      assign nd[i] = q;
    end else begin : g_cmb
      assign nd[i] = cmb;
    end
  end

  assign root = nd[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_nxt = (RED_LAT == 0) ? COMMIT : REDUCE;
        end
      end
      REDUCE: begin
        if (cnt_inc == CW'(RED_LAT)) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
      COMMIT:  commit    = 1'b1;
      default: ;
    endcase
  end

  assign accept = req_ready && bus.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == REDUCE) begin
      cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_times <= '0;
      cap_vld   <= '0;
      cap_ne    <= '0;
      cap_nev   <= 1'b0;
    end else if (accept) begin
      cap_times <= bus.core_times;
      cap_vld   <= bus.core_vld;
      cap_ne    <= bus.next_event;
      cap_nev   <= bus.next_event_vld;
    end
  end

  // A lower candidate is reported but never lowers gvt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gvt_q     <= '0;
      src_q     <= '1;
      done_q    <= 1'b0;
      regress_q <= 1'b0;
    end else begin
      done_q    <= commit;
      regress_q <= 1'b0;
      if (commit) begin
        if (!root.vld) begin
          src_q <= '1;
        end else if (root.val >= gvt_q) begin
          gvt_q <= root.val;
          src_q <= root.src;
        end else begin
          src_q     <= root.src;
          regress_q <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.busy      = ~req_ready;
  assign bus.gvt       = gvt_q;
  assign bus.done      = done_q;
  assign bus.min_src   = src_q;
  assign bus.regress   = regress_q;

endmodule

// File: tb/tb_gvt_tracker.sv
// Directed and swept checks for gvt_tracker.
// Expected commits are queued at accept and popped on done.
module tb_gvt_tracker;

  typedef struct {
    int          k;
    logic [15:0] gvt;
    logic [3:0]  src;
    logic        rg;
    int          lat;
  } exp_t;

  localparam int NSW = 5;
  localparam int SW_NC  [NSW] = '{1, 3, 4, 8, 8};
  localparam int SW_PE  [NSW] = '{0, 1, 2, 0, 1};
  localparam int SW_LAT [NSW] = '{1, 3, 3, 1, 5};
  localparam int SW_L   [NSW] = '{1, 2, 3, 4, 4};

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [15:0]  st_t [8];
  logic [127:0] st_flat;
  logic [7:0]   st_v;
  logic [15:0]  st_ne;
  logic         st_nev;
  logic         m_req;
  logic         sw_req;

  exp_t mq [$];
  exp_t sq [$];
  logic [15:0] mg [NSW];

  always #5 clk = ~clk;

  always_comb begin
    st_flat = '0;
    for (int i = 0; i < 8; i++) st_flat[16*i +: 16] = st_t[i];
  end

  gvt_tracker_if #(.NUM_CORE(5), .TIME_WID(16)) bus ();

  gvt_tracker #(
    .NUM_CORE(5),
    .TIME_WID(16),
    .PIPE_EVERY(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.req_valid      = m_req;
  assign bus.core_times     = st_flat[79:0];
  assign bus.core_vld       = st_v[4:0];
  assign bus.next_event     = st_ne;
  assign bus.next_event_vld = st_nev;

  wire [NSW-1:0] sw_done;
  wire [NSW-1:0] sw_ready;
  wire [NSW-1:0] sw_reg;
  wire [15:0]    sw_gvt [NSW];
  wire [3:0]     sw_src [NSW];

  for (genvar k = 0; k < NSW; k++) begin : g_sw
    gvt_tracker_if #(.NUM_CORE(SW_NC[k]), .TIME_WID(16)) sb ();

    gvt_tracker #(
      .NUM_CORE(SW_NC[k]),
      .TIME_WID(16),
      .PIPE_EVERY(SW_PE[k])
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (sb)
    );

    assign sb.req_valid      = sw_req;
    assign sb.core_times     = st_flat[16*SW_NC[k]-1:0];
    assign sb.core_vld       = st_v[SW_NC[k]-1:0];
    assign sb.next_event     = st_ne;
    assign sb.next_event_vld = st_nev;
    assign sw_done[k]  = sb.done;
    assign sw_ready[k] = sb.req_ready && !sb.busy;
    assign sw_reg[k]   = sb.regress;
    assign sw_gvt[k]   = sb.gvt;
    assign sw_src[k]   = 4'(sb.min_src);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: lowest valid time wins, ties to lower index.
  task automatic model(input int n, input int l,
                       input logic [15:0] g_in,
                       output logic [15:0] g_out,
                       output logic [3:0] src,
                       output logic rg);
    int best;
    logic [15:0] bv;
    logic vv;
    logic [15:0] tv;
    best = -1;
    bv = '0;
    for (int i = 0; i <= n; i++) begin
      vv = (i < n) ? st_v[i] : st_nev;
      tv = (i < n) ? st_t[i] : st_ne;
      if (vv && (best < 0 || tv < bv)) begin
        best = i;
        bv = tv;
      end
    end
    rg = 1'b0;
    g_out = g_in;
    if (best < 0) begin
      src = 4'((1 << l) - 1);
    end else begin
      src = 4'(best);
      if (bv >= g_in) g_out = bv;
      else rg = 1'b1;
    end
  endtask

  task automatic set5(input int a, input int b, input int c,
                      input int d, input int e);
    st_t[0] = 16'(a);
    st_t[1] = 16'(b);
    st_t[2] = 16'(c);
    st_t[3] = 16'(d);
    st_t[4] = 16'(e);
  endtask

  task automatic main_req(input string tag,
                          input logic [15:0] eg,
                          input logic [3:0] es,
                          input logic er);
    exp_t e;
    bit got;
    chk({tag, "_ready"}, bus.req_ready, 1);
    m_req = 1'b1;
    @(posedge clk);
    e = '{k: -1, gvt: eg, src: es, rg: er, lat: 4};
    mq.push_back(e);
    #1 m_req = 1'b0;
    got = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        got = 1;
        e = mq.pop_front();
        chk({tag, "_gvt"}, bus.gvt, e.gvt);
        chk({tag, "_src"}, bus.min_src, e.src);
        chk({tag, "_regress"}, bus.regress, e.rg);
        chk({tag, "_lat"}, c, e.lat);
      end
    end
    chk({tag, "_done"}, got, 1);
  endtask

  initial begin
    exp_t e;
    bit got;
    int seen;
    int cyc;
    int idx;
    logic [15:0] g;
    logic [3:0] s;
    logic r;

    rst_n = 1'b0;
    m_req = 1'b0;
    sw_req = 1'b0;
    for (int i = 0; i < 8; i++) st_t[i] = '0;
    st_v = '0;
    st_ne = '0;
    st_nev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gvt", bus.gvt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_regress", bus.regress, 0);
    chk("rst_src", bus.min_src, 7);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    set5(40, 25, 60, 25, 90);
    st_v = 8'h1f;
    st_ne = 16'd70;
    st_nev = 1'b1;
    main_req("basic", 16'd25, 4'd1, 1'b0);

    set5(10, 20, 30, 40, 50);
    st_v = 8'h00;
    st_ne = 16'd35;
    main_req("queue_win", 16'd35, 4'd5, 1'b0);

    st_nev = 1'b0;
    main_req("none_valid", 16'd35, 4'd7, 1'b0);

    set5(12, 50, 60, 70, 80);
    st_v = 8'h1f;
    main_req("regress", 16'd35, 4'd0, 1'b1);

    // Snapshot, ignored busy request, then back-to-back.
    set5(100, 110, 120, 130, 140);
    chk("snap_ready", bus.req_ready, 1);
    m_req = 1'b1;
    @(posedge clk);
    e = '{k: -1, gvt: 16'd100, src: 4'd0, rg: 1'b0, lat: 4};
    mq.push_back(e);
    #1 m_req = 1'b0;
    set5(1, 1, 1, 1, 1);
    @(posedge clk);
    #1;
    chk("snap_busy", bus.busy, 1);
    chk("snap_not_ready", bus.req_ready, 0);
    m_req = 1'b1;
    @(posedge clk);
    #1 m_req = 1'b0;
    cyc = 2;
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) begin
        got = 1;
        e = mq.pop_front();
        chk("snap_gvt", bus.gvt, e.gvt);
        chk("snap_src", bus.min_src, e.src);
        chk("snap_lat", cyc, e.lat);
        chk("b2b_ready", bus.req_ready, 1);
      end
    end
    chk("snap_done", got, 1);
    set5(200, 210, 220, 230, 240);
    m_req = 1'b1;
    @(posedge clk);
    e = '{k: -1, gvt: 16'd200, src: 4'd0, rg: 1'b0, lat: 5};
    mq.push_back(e);
    #1 m_req = 1'b0;
    cyc = 1;
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) begin
        got = 1;
        e = mq.pop_front();
        chk("b2b_gvt", bus.gvt, e.gvt);
        chk("b2b_spacing", cyc, e.lat);
      end
    end
    chk("b2b_done", got, 1);

    // Abort in REDUCE.
    set5(300, 310, 320, 330, 340);
    m_req = 1'b1;
    @(posedge clk);
    #1 m_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_gvt", bus.gvt, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_src", bus.min_src, 7);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) seen++;
    end
    chk("mid_rst_no_done", seen, 0);

    set5(5, 9, 9, 9, 9);
    main_req("after_rst", 16'd5, 4'd0, 1'b0);

    for (int k = 0; k < NSW; k++) mg[k] = '0;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 8; i++) begin
        st_t[i] = 16'($urandom_range(0, 400) + it * 100);
      end
      st_v = 8'($urandom);
      st_ne = 16'($urandom_range(0, 400) + it * 100);
      st_nev = ($urandom_range(0, 3) != 0);
      chk($sformatf("sw_ready_it%0d", it), sw_ready, {NSW{1'b1}});
      sw_req = 1'b1;
      @(posedge clk);
      for (int k = 0; k < NSW; k++) begin
        model(SW_NC[k], SW_L[k], mg[k], g, s, r);
        mg[k] = g;
        e = '{k: k, gvt: g, src: s, rg: r, lat: SW_LAT[k]};
        sq.push_back(e);
      end
      #1 sw_req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk);
        #1;
        for (int k = 0; k < NSW; k++) begin
          if (sw_done[k] === 1'b1) begin
            idx = -1;
            for (int j = 0; j < sq.size(); j++) begin
              if (idx < 0 && sq[j].k == k) idx = j;
            end
            chk($sformatf("sw%0d_match", k), idx >= 0, 1);
            if (idx >= 0) begin
              e = sq[idx];
              sq.delete(idx);
              chk($sformatf("sw%0d_gvt", k), sw_gvt[k], e.gvt);
              chk($sformatf("sw%0d_src", k), sw_src[k], e.src);
              chk($sformatf("sw%0d_reg", k), sw_reg[k], e.rg);
              chk($sformatf("sw%0d_lat", k), c, e.lat);
            end
          end
        end
      end
      chk($sformatf("sw_drain_it%0d", it), sq.size(), 0);
      sq.delete();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gvt_tracker.md
Name: gvt_tracker

Overview:
- Sequential, pipelined successor to the combinational GVT min-tree.
- On request, snapshots per-core times plus the event-queue head and reduces them through a registered min-tree. The tree supports any NUM_CORE, including non-power-of-two.
- Commits a monotonic GVT register, reports which source won, and flags any regression attempt.
- Sits between the core array and the global event queue; the scheduler's fossil-collection logic consumes the result.

Parameters:
- NUM_CORE, 4, number of cores; any value >= 1.
- TIME_WID, 16, timestamp width; unsigned, no wrap handling.
- PIPE_EVERY, 1, a register stage is inserted after every PIPE_EVERY tree levels; 0 = fully combinational tree.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  GVT computation request
- req_ready  out  1  block idle, request accepted when req_valid && req_ready at a rising edge
- core_times  in  TIME_WID*NUM_CORE  per-core local time, core i at [TIME_WID*i +: TIME_WID]
- core_vld  in  NUM_CORE  core i time participates
- next_event  in  TIME_WID  head timestamp of global event queue
- next_event_vld  in  1  queue non-empty
- gvt  out  TIME_WID  committed GVT
- done  out  1  one-cycle pulse, commit occurred
- min_src  out  clog2(NUM_CORE+1)  winning source index; NUM_CORE = next_event; all-ones = none
- regress  out  1  one-cycle pulse with done when the candidate was below gvt
- busy  out  1  inverse of req_ready

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: gvt=0, done=0, regress=0, min_src=all-ones, req_ready=1, busy=0, FSM=IDLE, all pipeline valids cleared.
- Leaves: NUM_CORE+1 entries, cores 0..NUM_CORE-1 followed by next_event at index NUM_CORE.
- Leaf padding: padded with invalid leaves up to 2^L, where L = clog2(NUM_CORE+1); minimum L=1.
- Tree node:
  - both inputs valid: output the smaller value; a tie goes to the lower source index.
  - one input valid: pass it through.
  - neither valid: output invalid.
  - each node also carries its source index.
- Reduction latency: RED_LAT = 0 if PIPE_EVERY=0, else ceil(L/PIPE_EVERY) cycles.
- FSM:
  - IDLE: req_ready=1. On accept at edge E0, snapshot core_times, core_vld, next_event and next_event_vld into capture registers, then go to REDUCE. Inputs may change freely after E0.
  - REDUCE: a counter runs RED_LAT cycles; go to COMMIT when the counter reaches RED_LAT (immediately if 0).
  - COMMIT: at edge E0+RED_LAT+1, registered outputs update and the FSM returns to IDLE. done is high for exactly the cycle following that edge. req_ready rises in that same cycle, so back-to-back requests are allowed. The minimum request spacing is RED_LAT+2 cycles.
- Commit rules:
  - candidate valid and >= gvt: load gvt=candidate and min_src=source.
  - candidate valid and < gvt: hold gvt, set min_src=source, pulse regress.
  - no valid source: hold gvt, min_src=all-ones, no regress.
- gvt never decreases except via reset.
- Requests while busy are ignored (not queued). req_valid must hold until accepted.
- Reset mid-operation: abort immediately; no done pulse follows reset release.

Test Plan:
- Reset: assert rst_n=0 mid-REDUCE -> gvt=0, done=0, req_ready=1; after release, no spurious done pulse.
- Basic reduction, NUM_CORE=5, PIPE_EVERY=1 (L=3, RED_LAT=3): times {40,25,60,25,90}, all valid, next_event=70 valid, request accepted at E0 -> done in the cycle after E0+4, gvt=25, min_src=1 (tie goes to index 1 over index 3).
- Queue wins with masking: times {10,20,30,40,50}, core_vld=5'b00000, next_event=35 valid -> gvt=35, min_src=5. Then next_event_vld=0 as well -> gvt holds 35, min_src=7, regress=0.
- Monotonic guard: gvt=35, then times {12,...} valid -> gvt stays 35, min_src=0, regress=1 coincident with done.
- Snapshot and busy: change core_times and pulse req_valid during REDUCE -> result reflects the E0 values; the second request is not accepted until req_ready=1. A back-to-back request accepted in the done cycle gives its done pulse RED_LAT+2 cycles later.
- Parameter sweep: NUM_CORE in {1,3,4,8}, PIPE_EVERY in {0,1,2} with random vectors -> gvt equals a reference min over the valid sources, clamped monotonic. Latency equals RED_LAT+1 edges after accept.
